framed_shift_register: RTL and testbench
========================================

# framed_shift_register

Parametrised successor to the 8-bit peripheral shift register. It adds a frame controller around the shift path: a bit counter, selectable MSB-first or LSB-first shifting, an explicit receive-start, and a one-cycle frame-complete pulse. It sits between the input conditioner (which supplies `peripheralClkEdge`) and the SPI-style peripheral logic that loads, transmits and captures whole words.

## Interface
- `WIDTH`, default 8, shift register and word width; legal range is WIDTH ≥ 2.
- `CNTW`, default `$clog2(WIDTH)`, width of the bit counter.

Ports:
- `clk` input, 1 bit, system clock; all state updates on the rising edge.
- `resetn` input, 1 bit, synchronous active-low reset, sampled on the rising edge of `clk`.
- `peripheralClkEdge` input, 1 bit, single-cycle shift strobe from the input conditioner.
- `parallelLoad` input, 1 bit, loads `parallelDataIn` and starts a transmit frame.
- `start` input, 1 bit, starts a frame without loading, used for receive.
- `lsbFirst` input, 1 bit, shift direction; sampled only on load or start.
- `parallelDataIn` input, WIDTH bits, word to load.
- `serialDataIn` input, 1 bit, bit shifted in on each strobe.
- `parallelDataOut` output, WIDTH bits, current register contents.
- `serialDataOut` output, 1 bit, current outgoing bit.
- `bitCount` output, CNTW bits, number of shifts completed in the current frame.
- `busy` output, 1 bit, high while a frame is in progress.
- `frameDone` output, 1 bit, one-cycle pulse when a frame completes.

## Operation
- State is the register `sr[WIDTH-1:0]`, the latched direction bit `dir`, the counter `cnt`, and a two-state FSM with states IDLE and ACTIVE.
- **Reset** (`resetn`=0 at a clock edge): `sr`=0, `dir`=0, `cnt`=0, FSM=IDLE, `frameDone`=0. Reset overrides every other input.
- **Priority** at each edge: reset, then `parallelLoad`, then `start`, then `peripheralClkEdge`.
- **Load** (any state): `sr`←`parallelDataIn`, `dir`←`lsbFirst`, `cnt`←0, FSM→ACTIVE. A load issued in ACTIVE aborts the current frame and does not pulse `frameDone`.
- **Start** (any state, no load): `sr` is unchanged, `dir`←`lsbFirst`, `cnt`←0, FSM→ACTIVE. A start in ACTIVE also aborts and restarts the frame.
- **Shift** (ACTIVE, strobe high, no load or start):
  - `dir`=0: `sr`←{`sr[WIDTH-2:0]`, `serialDataIn`}.
  - `dir`=1: `sr`←{`serialDataIn`, `sr[WIDTH-1:1]`}.
  - If `cnt`=WIDTH-1: `cnt`←0, FSM→IDLE, `frameDone`←1. Otherwise `cnt`←`cnt`+1.
- **IDLE**: strobes are ignored and `sr` holds. This differs from the predecessor, which shifted on every strobe.
- A strobe coincident with a load or start is dropped and does not count.
- `frameDone` is registered. It is high for exactly the one cycle after the final shift edge, and is 0 in every other cycle.
- Output mapping:
  - `serialDataOut` = `dir` ? `sr[0]` : `sr[WIDTH-1]` (combinational from registers).
  - `parallelDataOut` = `sr`.
  - `bitCount` = `cnt`.
  - `busy` = (FSM==ACTIVE).
- Reset values of all outputs: `parallelDataOut`=0, `serialDataOut`=0, `bitCount`=0, `busy`=0, `frameDone`=0.

## Timing
- Load or start to outputs: 1 cycle. The edge that samples `parallelLoad` updates `parallelDataOut` and `busy`. `serialDataOut` presents the first bit in the same cycle.
- Each accepted strobe updates `sr` and `cnt` at that edge. The next bit appears on `serialDataOut` in the following cycle.
- A frame is exactly WIDTH accepted strobes.
- On the final accepted strobe, at the same edge:
  - `busy` falls.
  - `frameDone` rises.
  - `parallelDataOut` holds the completed received word.
- `frameDone` falls at the next edge.
- Back-to-back frames: a load or start in the same cycle as the `frameDone` pulse is legal. `busy` stays high, and no IDLE cycle is required.
- Strobes closer together than 1 cycle cannot occur, because the conditioner guarantees single-cycle pulses. Consecutive-cycle strobes must all be accepted.
- Reset mid-frame takes effect at the next edge. The frame is discarded and no `frameDone` pulse is produced.

## Test plan
All scenarios use WIDTH=8.
- **Reset with competing inputs:** hold `resetn`=0 for 2 edges with `parallelLoad`=1, `parallelDataIn`=8'hFF, strobe=1 → all outputs 0, `busy`=0.
- **MSB-first transmit:** load 8'hA5 with `lsbFirst`=0 and `serialDataIn`=0, then apply 8 strobes spaced 3 cycles apart.
  - `serialDataOut` sequence is 1,0,1,0,0,1,0,1.
  - `bitCount` runs 0..7.
  - Exactly one `frameDone` pulse occurs after the 8th strobe, with `parallelDataOut`=8'h00 and `busy`=0.
- **LSB-first receive:** `start` with `lsbFirst`=1, then 8 strobes with `serialDataIn` = 1,1,0,0,1,0,1,0 → `parallelDataOut`=8'h53 when `frameDone`=1.
- **Dropped strobes:** a strobe in IDLE leaves `parallelDataOut` unchanged. A load of 8'h3C with a coincident strobe gives `parallelDataOut`=8'h3C and `bitCount`=0.
- **Load mid-frame:** load 8'hF0, apply 3 strobes, then load 8'h81.
  - No `frameDone` pulse from the first frame.
  - `bitCount`=0 after the second load.
  - 8 further strobes are needed before `frameDone` fires.
- **Reset mid-frame:** assert reset after 4 strobes of a frame → all outputs 0. No `frameDone` pulse. Later strobes are ignored until the next load or start.

Source files
------------

// File: rtl/framed_shift_register_if.sv
// Shift-register bus: frame controls and data going into the shift path,
// plus the word, bit and frame status coming back out of it.
interface framed_shift_register_if #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH)
);
   logic             peripheralClkEdge;
   logic             parallelLoad;
   logic             start;
   logic             lsbFirst;
   logic [WIDTH-1:0] parallelDataIn;
   logic             serialDataIn;
   logic [WIDTH-1:0] parallelDataOut;
   logic             serialDataOut;
   logic [CNTW-1:0]  bitCount;
   logic             busy;
   logic             frameDone;

   // Peripheral logic side: issues loads, starts and strobes, observes status.
   modport master (
      output peripheralClkEdge, parallelLoad, start, lsbFirst,
             parallelDataIn, serialDataIn,
      input  parallelDataOut, serialDataOut, bitCount, busy, frameDone
   );

   // Shift register side.
   modport slave (
      input  peripheralClkEdge, parallelLoad, start, lsbFirst,
             parallelDataIn, serialDataIn,
      output parallelDataOut, serialDataOut, bitCount, busy, frameDone
   );
endinterface

// File: rtl/framed_shift_register.sv
// Framed shift register: a WIDTH-bit shift path wrapped by a frame controller.
// A frame begins on a load (transmit) or a start (receive), accepts exactly
// WIDTH strobes in MSB-first or LSB-first order, then returns to IDLE with a
// one-cycle frameDone pulse. Strobes arriving while IDLE are ignored.
module framed_shift_register #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input logic                    clk,
   input logic                    resetn,
   framed_shift_register_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

   state_t           state_r;
   logic [WIDTH-1:0] shiftReg_r;
   logic             dir_r;
   logic [CNTW-1:0]  cnt_r;
   logic             frameDone_r;
   logic [WIDTH-1:0] shiftNext_s;

   // Next register contents for one shift in the latched direction.
   always_comb begin
      shiftNext_s = shiftReg_r;
      if (dir_r) begin
         shiftNext_s = {bus.serialDataIn, shiftReg_r[WIDTH-1:1]};
      end else begin
         shiftNext_s = {shiftReg_r[WIDTH-2:0], bus.serialDataIn};
      end
   end

   // Frame controller and shift path; load beats start beats strobe.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r     <= IDLE;
         shiftReg_r  <= {WIDTH{1'b0}};
         dir_r       <= 1'b0;
         cnt_r       <= {CNTW{1'b0}};
         frameDone_r <= 1'b0;
      end else begin
         frameDone_r <= 1'b0;
         if (bus.parallelLoad) begin
            // Aborting an active frame here deliberately produces no pulse.
            shiftReg_r <= bus.parallelDataIn;
            dir_r      <= bus.lsbFirst;
            cnt_r      <= {CNTW{1'b0}};
            state_r    <= ACTIVE;
         end else if (bus.start) begin
            dir_r   <= bus.lsbFirst;
            cnt_r   <= {CNTW{1'b0}};
            state_r <= ACTIVE;
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
               end
               ACTIVE: begin
                  if (bus.peripheralClkEdge) begin
                     shiftReg_r <= shiftNext_s;
                     if (cnt_r == LAST_BIT) begin
                        cnt_r       <= {CNTW{1'b0}};
                        state_r     <= IDLE;
                        frameDone_r <= 1'b1;
                     end else begin
                        cnt_r <= cnt_r + CNTW'(1);
                     end
                  end else begin
                     state_r <= ACTIVE;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  cnt_r   <= {CNTW{1'b0}};
               end
            endcase
         end
      end
   end

   assign bus.parallelDataOut = shiftReg_r;
   assign bus.serialDataOut   = dir_r ? shiftReg_r[0] : shiftReg_r[WIDTH-1];
   assign bus.bitCount        = cnt_r;
   assign bus.busy            = (state_r == ACTIVE);
   assign bus.frameDone       = frameDone_r;

endmodule

// File: tb/tb_framed_shift_register.sv
// Directed plus randomized bench for framed_shift_register (WIDTH=8).
// A word-level reference model predicts every output after every edge; the
// directed scenarios additionally compare against hand-derived constants.
module tb_framed_shift_register;

   localparam int W = 8;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   framed_shift_register_if #(.WIDTH(W)) bus ();

   framed_shift_register #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   string phase = "init";

   // Reference model: word value, direction, shifts done, frame open, pulse.
   int mSr = 0;
   int mDir = 0;
   int mCnt = 0;
   int mActive = 0;
   int mDone = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic modelEdge(input bit rstn, input bit ld, input bit st, input bit stb,
                            input bit lsb, input logic [7:0] din, input bit sin);
      mDone = 0;
      if (!rstn) begin
         mSr = 0; mDir = 0; mCnt = 0; mActive = 0;
      end else if (ld) begin
         mSr = int'(din); mDir = int'(lsb); mCnt = 0; mActive = 1;
      end else if (st) begin
         mDir = int'(lsb); mCnt = 0; mActive = 1;
      end else if (stb && mActive == 1) begin
         if (mDir == 1) mSr = (mSr / 2) + (sin ? 128 : 0);
         else           mSr = ((mSr * 2) % 256) + (sin ? 1 : 0);
         mCnt = mCnt + 1;
         if (mCnt == W) begin
            mCnt = 0; mActive = 0; mDone = 1;
         end
      end
   endtask

   task automatic step(input bit rstn, input bit ld, input bit st, input bit stb,
                       input bit lsb, input logic [7:0] din, input bit sin);
      resetn                = rstn;
      bus.parallelLoad      = ld;
      bus.start             = st;
      bus.peripheralClkEdge = stb;
      bus.lsbFirst          = lsb;
      bus.parallelDataIn    = din;
      bus.serialDataIn      = sin;
      @(posedge clk);
      #1;
      modelEdge(rstn, ld, st, stb, lsb, din, sin);
      check("parallelDataOut", 32'(bus.parallelDataOut), 32'(mSr));
      check("serialDataOut", 32'(bus.serialDataOut),
            32'((mDir == 1) ? (mSr % 2) : ((mSr / 128) % 2)));
      check("bitCount", 32'(bus.bitCount), 32'(mCnt));
      check("busy", 32'(bus.busy), 32'(mActive));
      check("frameDone", 32'(bus.frameDone), 32'(mDone));
      if (bus.frameDone === 1'b1) pulses++;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic strobe(input bit sin);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, sin);
   endtask

   task automatic load(input logic [7:0] din, input bit lsb);
      step(1'b1, 1'b1, 1'b0, 1'b0, lsb, din, 1'b0);
   endtask

   task automatic startFrame(input bit lsb);
      step(1'b1, 1'b0, 1'b1, 1'b0, lsb, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] txWord;
      logic [7:0] rxBits;

      bus.parallelLoad      = 1'b0;
      bus.start             = 1'b0;
      bus.peripheralClkEdge = 1'b0;
      bus.lsbFirst          = 1'b0;
      bus.parallelDataIn    = 8'h00;
      bus.serialDataIn      = 1'b0;

      // Reset held with competing load and strobe.
      phase = "reset";
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
      check("rstPdo", 32'(bus.parallelDataOut), 32'h0);
      check("rstBusy", 32'(bus.busy), 32'h0);
      check("rstSdo", 32'(bus.serialDataOut), 32'h0);

      // MSB-first transmit of A5, strobes 3 cycles apart.
      phase = "msbTx";
      txWord = 8'hA5;
      pulses = 0;
      load(8'hA5, 1'b0);
      for (int i = 0; i < W; i++) begin
         check("txBit", 32'(bus.serialDataOut), 32'(txWord[W-1-i]));
         check("txCount", 32'(bus.bitCount), 32'(i));
         idle();
         idle();
         strobe(1'b0);
      end
      check("txDone", 32'(bus.frameDone), 32'h1);
      check("txWordOut", 32'(bus.parallelDataOut), 32'h00);
      check("txBusy", 32'(bus.busy), 32'h0);
      idle();
      check("txDoneFall", 32'(bus.frameDone), 32'h0);
      check("txPulses", 32'(pulses), 32'd1);

      // LSB-first receive with back-to-back strobes.
      phase = "lsbRx";
      rxBits = 8'b0101_0011;
      startFrame(1'b1);
      for (int i = 0; i < W; i++) strobe(rxBits[i]);
      check("rxDone", 32'(bus.frameDone), 32'h1);
      check("rxWord", 32'(bus.parallelDataOut), 32'h53);

      // Strobe in IDLE is dropped; strobe coincident with load is dropped.
      phase = "dropped";
      strobe(1'b1);
      check("idleHold", 32'(bus.parallelDataOut), 32'h53);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1);
      check("loadStbWord", 32'(bus.parallelDataOut), 32'h3C);
      check("loadStbCount", 32'(bus.bitCount), 32'h0);

      // Load mid-frame aborts without a pulse; new frame needs 8 strobes.
      phase = "loadMid";
      pulses = 0;
      load(8'hF0, 1'b0);
      for (int i = 0; i < 3; i++) strobe(1'b1);
      load(8'h81, 1'b0);
      check("midCount", 32'(bus.bitCount), 32'h0);
      for (int i = 0; i < W - 1; i++) strobe(1'b0);
      check("midNoDone", 32'(pulses), 32'd0);
      strobe(1'b0);
      check("midDone", 32'(bus.frameDone), 32'h1);

      // Start issued during the frameDone cycle keeps busy high.
      phase = "backToBack";
      startFrame(1'b0);
      check("b2bBusy", 32'(bus.busy), 32'h1);
      check("b2bPulses", 32'(pulses), 32'd1);

      // Reset after 4 strobes discards the frame; later strobes ignored.
      phase = "resetMid";
      pulses = 0;
      load(8'hC3, 1'b1);
      for (int i = 0; i < 4; i++) strobe(1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("rmPdo", 32'(bus.parallelDataOut), 32'h0);
      check("rmBusy", 32'(bus.busy), 32'h0);
      for (int i = 0; i < 6; i++) strobe(1'b1);
      check("rmHold", 32'(bus.parallelDataOut), 32'h0);
      check("rmPulses", 32'(pulses), 32'd0);

      // Randomized traffic checked cycle by cycle against the model.
      phase = "random";
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) != 0),
              ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
